w_handler: RTL and testbench

W_HANDLER -- requirements
Module: w_handler

---
 rtl/w_handler.sv | 174 +++++++++++++++++
 tb/tb_w_handler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_handler.sv
// W channel handler for an AXI write master.
// Queues accepted AW burst lengths, drives the W beats of each burst from a
// 32-bit data generator, and tracks B responses, completions and errors.
// Build option: define W_HANDLER_LFSR_EN to source W data from a 32-bit
// Galois LFSR instead of the default incrementing counter.
module w_handler #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    aw_fire_i,
  input  logic [7:0]              aw_len_i,
  output logic                    aw_ok_o,
  output logic                    w_valid_o,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  input  logic                    w_ready_i,
  input  logic                    b_valid_i,
  input  logic [1:0]              b_resp_i,
  output logic                    b_ready_o,
  output logic [7:0]              outstanding_o,
  output logic [15:0]             done_cnt_o,
  output logic [15:0]             err_cnt_o,
  output logic                    overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REPL  = DATA_WIDTH / 32;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, DATA} state_t;

  state_t state_q, state_d;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop;

  logic [7:0]  beat_cnt_q, cur_len_q;
  logic [31:0] gen_q, gen_next;

  logic        b_ready_q;
  logic [7:0]  outstanding_q;
  logic [15:0] done_cnt_q, err_cnt_q, err_cnt_d;
  logic        overflow_q;

  logic        w_hs, last_hs, b_hs, spurious, b_err;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == '0);
  assign push = aw_fire_i & (~fifo_full | pop);
  assign drop = aw_fire_i & fifo_full & ~pop;

  assign w_valid_o = (state_q == DATA);
  assign w_last_o  = w_valid_o & (beat_cnt_q == cur_len_q);
  assign w_data_o  = w_valid_o ? {REPL{gen_q}} : '0;
  assign w_strb_o  = w_valid_o ? '1 : '0;

  assign w_hs    = w_valid_o & w_ready_i;
  assign last_hs = w_hs & w_last_o;
  assign b_hs    = b_valid_i & b_ready_q;
  // A response with nothing outstanding and no completion this cycle is bogus.
  assign spurious = b_hs & (outstanding_q == '0) & ~last_hs;
  assign b_err    = b_hs & ((b_resp_i != 2'b00) | spurious);

  assign aw_ok_o       = ~fifo_full;
  assign b_ready_o     = b_ready_q;
  assign outstanding_o = outstanding_q;
  assign done_cnt_o    = done_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign overflow_o    = overflow_q;

`ifdef W_HANDLER_LFSR_EN
  assign gen_next = {1'b0, gen_q[31:1]} ^ (gen_q[0] ? 32'h8020_0003 : 32'h0000_0000);
`else
  assign gen_next = gen_q + 32'd1;
`endif

  // Next-state logic: start a burst whenever a length is queued, leave after its last beat.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Length FIFO storage; contents are meaningless until counted in.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= aw_len_i;
  end

  // Length FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Burst tracking and data generator: load on pop, advance on every accepted beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
      cur_len_q  <= '0;
      gen_q      <= 32'h0000_0001;
    end else if (pop) begin
      beat_cnt_q <= '0;
      cur_len_q  <= fifo_mem[rd_ptr_q];
    end else if (w_hs) begin
      beat_cnt_q <= beat_cnt_q + 8'd1;
      gen_q      <= gen_next;
    end
  end

  // Error events this cycle (dropped AW, bad or spurious B) summed with saturation.
  always_comb begin
    err_inc   = {1'b0, drop} + {1'b0, b_err};
    err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Response side bookkeeping: ready, outstanding, completion and error counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_ready_q     <= 1'b0;
      outstanding_q <= '0;
      done_cnt_q    <= '0;
      err_cnt_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      b_ready_q <= 1'b1;
      if (last_hs && !b_hs) begin
        if (outstanding_q != 8'hFF) outstanding_q <= outstanding_q + 8'd1;
      end else if (b_hs && !last_hs) begin
        if (outstanding_q != 8'h00) outstanding_q <= outstanding_q - 8'd1;
      end
      if (b_hs && !spurious && done_cnt_q != 16'hFFFF) done_cnt_q <= done_cnt_q + 16'd1;
      err_cnt_q <= err_cnt_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_w_handler.sv
// Self-checking bench for w_handler: expected W beats are queued when an AW is
// issued and compared beat by beat as the DUT presents them.
module tb_w_handler;

  logic        clk_i;
  logic        rst_i;
  logic        aw_fire_i;
  logic [7:0]  aw_len_i;
  logic        aw_ok_o;
  logic        w_valid_o;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        w_last_o;
  logic        w_ready_i;
  logic        b_valid_i;
  logic [1:0]  b_resp_i;
  logic        b_ready_o;
  logic [7:0]  outstanding_o;
  logic [15:0] done_cnt_o;
  logic [15:0] err_cnt_o;
  logic        overflow_o;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] exp_gen;
  int          tests_run;
  int          tests_failed;

  w_handler #(.DATA_WIDTH(64), .FIFO_DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .aw_fire_i     (aw_fire_i),
    .aw_len_i      (aw_len_i),
    .aw_ok_o       (aw_ok_o),
    .w_valid_o     (w_valid_o),
    .w_data_o      (w_data_o),
    .w_strb_o      (w_strb_o),
    .w_last_o      (w_last_o),
    .w_ready_i     (w_ready_i),
    .b_valid_i     (b_valid_i),
    .b_resp_i      (b_resp_i),
    .b_ready_o     (b_ready_o),
    .outstanding_o (outstanding_o),
    .done_cnt_o    (done_cnt_o),
    .err_cnt_o     (err_cnt_o),
    .overflow_o    (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] gen_step(input logic [31:0] g);
`ifdef W_HANDLER_LFSR_EN
    return {1'b0, g[31:1]} ^ (g[0] ? 32'h8020_0003 : 32'h0000_0000);
`else
    return g + 32'd1;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one AW; if it is expected to be accepted, queue its beats.
  task automatic applyStimulus(input logic [7:0] len, input bit accepted);
    aw_fire_i = 1'b1;
    aw_len_i  = len;
    if (accepted) begin
      for (int i = 0; i <= int'(len); i++) begin
        beat_t b;
        b.data  = {2{exp_gen}};
        b.last  = (i == int'(len));
        sb.push_back(b);
        exp_gen = gen_step(exp_gen);
      end
    end
    tick();
    aw_fire_i = 1'b0;
  endtask

  task automatic sendB(input logic [1:0] resp);
    b_valid_i = 1'b1;
    b_resp_i  = resp;
    tick();
    b_valid_i = 1'b0;
    b_resp_i  = 2'b00;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: every presented beat must match the queue head, also while stalled.
  always @(negedge clk_i) begin
    if (!rst_i && w_valid_o) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", {32'd0, w_data_o[31:0]}, 64'hDEAD);
      end else begin
        checkOutput("w_data", w_data_o, sb[0].data);
        checkOutput("w_last", 64'(w_last_o), 64'(sb[0].last));
        checkOutput("w_strb", 64'(w_strb_o), 64'hFF);
        if (w_ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_gen      = 32'h0000_0001;
    rst_i        = 1'b1;
    aw_fire_i    = 1'b0;
    aw_len_i     = 8'd0;
    w_ready_i    = 1'b0;
    b_valid_i    = 1'b0;
    b_resp_i     = 2'b00;

    // Reset state
    tick();
    tick();
    checkOutput("rst_w_valid", 64'(w_valid_o), 64'd0);
    checkOutput("rst_w_last", 64'(w_last_o), 64'd0);
    checkOutput("rst_w_data", w_data_o, 64'd0);
    checkOutput("rst_b_ready", 64'(b_ready_o), 64'd0);
    checkOutput("rst_aw_ok", 64'(aw_ok_o), 64'd1);
    checkOutput("rst_outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("rst_done", 64'(done_cnt_o), 64'd0);
    checkOutput("rst_err", 64'(err_cnt_o), 64'd0);
    checkOutput("rst_overflow", 64'(overflow_o), 64'd0);
    rst_i = 1'b0;
    tick();
    checkOutput("b_ready_after_rst", 64'(b_ready_o), 64'd1);

    // Basic len=3 burst, data 1..4, then OKAY response
    w_ready_i = 1'b1;
    applyStimulus(8'd3, 1'b1);
    waitDrain();
    checkOutput("idle_after_burst", 64'(w_valid_o), 64'd0);
    checkOutput("outst_after_burst", 64'(outstanding_o), 64'd1);
    sendB(2'b00);
    checkOutput("outst_after_b", 64'(outstanding_o), 64'd0);
    checkOutput("done_after_b", 64'(done_cnt_o), 64'd1);
    checkOutput("err_after_b", 64'(err_cnt_o), 64'd0);

    // len=1 burst with a 3-cycle stall on beat 0
    w_ready_i = 1'b0;
    applyStimulus(8'd1, 1'b1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("stall_valid", 64'(w_valid_o), 64'd1);
    w_ready_i = 1'b1;
    waitDrain();
    sendB(2'b00);
    checkOutput("done_after_stall", 64'(done_cnt_o), 64'd2);

    // SLVERR response, then a spurious response
    applyStimulus(8'd0, 1'b1);
    waitDrain();
    sendB(2'b10);
    checkOutput("slverr_err", 64'(err_cnt_o), 64'd1);
    checkOutput("slverr_done", 64'(done_cnt_o), 64'd3);
    checkOutput("slverr_outst", 64'(outstanding_o), 64'd0);
    sendB(2'b00);
    checkOutput("spurious_err", 64'(err_cnt_o), 64'd2);
    checkOutput("spurious_done", 64'(done_cnt_o), 64'd3);
    checkOutput("spurious_outst", 64'(outstanding_o), 64'd0);

    // Fill the length FIFO behind a stalled burst, then overflow it
    w_ready_i = 1'b0;
    applyStimulus(8'd0, 1'b1);
    tick();
    tick();
    checkOutput("fill_aw_ok0", 64'(aw_ok_o), 64'd1);
    applyStimulus(8'd0, 1'b1);
    applyStimulus(8'd0, 1'b1);
    applyStimulus(8'd0, 1'b1);
    checkOutput("fill_aw_ok3", 64'(aw_ok_o), 64'd1);
    applyStimulus(8'd0, 1'b1);
    checkOutput("fill_aw_ok4", 64'(aw_ok_o), 64'd0);
    checkOutput("fill_no_ovf", 64'(overflow_o), 64'd0);
    applyStimulus(8'd0, 1'b0);
    checkOutput("ovf_flag", 64'(overflow_o), 64'd1);
    checkOutput("ovf_err", 64'(err_cnt_o), 64'd3);
    w_ready_i = 1'b1;
    waitDrain();
    checkOutput("ovf_outst", 64'(outstanding_o), 64'd5);
    checkOutput("ovf_aw_ok", 64'(aw_ok_o), 64'd1);
    for (int i = 0; i < 5; i++) sendB(2'b00);
    checkOutput("ovf_outst_drained", 64'(outstanding_o), 64'd0);
    checkOutput("ovf_done", 64'(done_cnt_o), 64'd8);
    checkOutput("ovf_sticky", 64'(overflow_o), 64'd1);

    // Last beat and B handshake on the same edge leave outstanding unchanged
    applyStimulus(8'd0, 1'b1);
    waitDrain();
    checkOutput("coinc_pre", 64'(outstanding_o), 64'd1);
    applyStimulus(8'd0, 1'b1);
    tick();
    sendB(2'b00);
    checkOutput("coinc_outst", 64'(outstanding_o), 64'd1);
    checkOutput("coinc_done", 64'(done_cnt_o), 64'd9);
    checkOutput("coinc_sb", 64'(sb.size()), 64'd0);
    sendB(2'b00);
    checkOutput("coinc_final", 64'(outstanding_o), 64'd0);

    // Reset on beat 2 of a len=7 burst aborts it
    applyStimulus(8'd7, 1'b1);
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    sb.delete();
    exp_gen = 32'h0000_0001;
    checkOutput("abort_valid", 64'(w_valid_o), 64'd0);
    checkOutput("abort_done", 64'(done_cnt_o), 64'd0);
    checkOutput("abort_err", 64'(err_cnt_o), 64'd0);
    checkOutput("abort_outst", 64'(outstanding_o), 64'd0);
    checkOutput("abort_ovf", 64'(overflow_o), 64'd0);
    checkOutput("abort_aw_ok", 64'(aw_ok_o), 64'd1);
    checkOutput("abort_b_ready", 64'(b_ready_o), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("abort_no_resume", 64'(w_valid_o), 64'd0);

    // Generator restarts from its seed after reset
    applyStimulus(8'd1, 1'b1);
    waitDrain();
    sendB(2'b00);
    checkOutput("post_rst_done", 64'(done_cnt_o), 64'd1);
    checkOutput("post_rst_outst", 64'(outstanding_o), 64'd0);

    tick();
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
